// File: rtl/vec_mem_sequencer_if.sv
// Single-element data-memory port between the vector sequencer and data memory.
// The sequencer drives address, strobes and write data. The memory returns read
// data together with a ready handshake.
interface vec_mem_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Serializes one vector load or store of LANES elements onto a single-element
// memory port. While it walks the lanes it holds the upstream pipeline frozen.
// When it finishes, it releases the pipeline with the assembled load vector valid.
module vec_mem_sequencer #(
  parameter int LANES      = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ELEM_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_rd,
  input  logic                    start_wr,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*DATA_W-1:0] wdata_vec,
  vec_mem_sequencer_if.master     mem,
  output logic [LANES*DATA_W-1:0] rdata_vec,
  output logic                    stall,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]              state;
  logic                    op_wr;
  logic [IDX_W-1:0]        idx;
  logic [ADDR_W-1:0]       base_q;
  logic [LANES*DATA_W-1:0] wdata_q;

  logic start_any;
  logic accept;

  assign start_any = start_rd | start_wr;
  assign accept    = (state == S_IDLE) && start_any;

  // Control state: the FSM, the op type, the lane index and the assembled load vector.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      idx       <= '0;
      rdata_vec <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_any) begin
            state <= S_ACCESS;
            op_wr <= start_wr;  // write wins when both starts arrive together
            idx   <= '0;
          end
        end
        S_ACCESS: begin
          if (mem.mem_ready) begin
            if (!op_wr) begin
              rdata_vec[int'(idx)*DATA_W +: DATA_W] <= mem.mem_rdata;
            end
            if (idx == LAST_IDX) begin
              state <= S_FINISH;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Operand capture: base address and store data are latched when a request is accepted.
  // NOTE: these are pure data holding registers that are qualified by state, so they have no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q  <= base_addr;
      wdata_q <= wdata_vec;
    end
  end

  // Memory port drive: active only in ACCESS, and held steady while mem_ready is low.
  // NOTE: every output gets a default first so this block cannot infer a latch.
  always_comb begin
    mem.mem_re    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state == S_ACCESS) begin
      mem.mem_re    = ~op_wr;
      mem.mem_we    = op_wr;
      // Address arithmetic wraps modulo 2^ADDR_W by construction.
      mem.mem_addr  = base_q + ADDR_W'(idx) * ADDR_W'(ELEM_BYTES);
      mem.mem_wdata = wdata_q[int'(idx)*DATA_W +: DATA_W];
    end
  end

  // Pipeline status: stall asserts combinationally in the decode cycle of a request.
  always_comb begin
    stall = accept || (state == S_ACCESS);
    busy  = (state != S_IDLE);
    done  = (state == S_FINISH);
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer. It covers the reset state, a read, a write
// with a wait state, simultaneous start requests, address wrap, a mid-read reset,
// and a start request that arrives while the sequencer is busy.
module tb_vec_mem_sequencer;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic                    clk;
  logic                    rst_n;
  logic                    start_rd;
  logic                    start_wr;
  logic [ADDR_W-1:0]       base_addr;
  logic [LANES*DATA_W-1:0] wdata_vec;
  logic [LANES*DATA_W-1:0] rdata_vec;
  logic                    stall;
  logic                    busy;
  logic                    done;
  logic                    ready;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;

  vec_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  vec_mem_sequencer #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ELEM_BYTES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_rd  (start_rd),
    .start_wr  (start_wr),
    .base_addr (base_addr),
    .wdata_vec (wdata_vec),
    .mem       (mif.master),
    .rdata_vec (rdata_vec),
    .stall     (stall),
    .busy      (busy),
    .done      (done)
  );

  // Memory model: the read data is derived from the address.
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign mif.mem_rdata = mdata(mif.mem_addr);
  assign mif.mem_ready = ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses and completed element transfers. Counting happens on the falling edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if ((mif.mem_re || mif.mem_we) && ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Checks, in one comparison: the strobes, address, write data, stall, busy and done.
  task automatic chk_cyc(input string tag, input logic re, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic st, input logic bs, input logic dn);
    check(tag, {57'd0, mif.mem_re, mif.mem_we, mif.mem_addr, mif.mem_wdata, stall, busy, done},
               {57'd0, re, we, addr, wd, st, bs, dn});
  endtask

  // Advance to the next cycle. Inputs change 1 ns after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] exp_rd1;
  logic [127:0] exp_wrap;
  logic [127:0] exp_rd5;
  int d0;
  int a0;

  initial begin
    rst_n = 1'b0; start_rd = 1'b0; start_wr = 1'b0;
    base_addr = '0; wdata_vec = '0; ready = 1'b1;
    exp_rd1  = {mdata(32'h10C), mdata(32'h108), mdata(32'h104), mdata(32'h100)};
    exp_wrap = {mdata(32'h4), mdata(32'h0), mdata(32'hFFFF_FFFC), mdata(32'hFFFF_FFF8)};
    exp_rd5  = {mdata(32'h50C), mdata(32'h508), mdata(32'h504), mdata(32'h500)};

    // Reset state
    #12;
    chk_cyc("reset_outputs", 0, 0, 32'h0, 32'h0, 0, 0, 0);
    check("reset_rdata", rdata_vec, 128'h0);
    next_cycle();
    rst_n = 1'b1;

    // Read at base 0x100 with ready held high. A start_rd pulse during busy must be ignored.
    next_cycle();
    d0 = done_cnt; a0 = acc_cnt;
    start_rd = 1'b1; base_addr = 32'h100; #1;
    chk_cyc("rd_c0", 0, 0, 32'h0, 32'h0, 1, 0, 0);
    next_cycle(); start_rd = 1'b0; #1;
    chk_cyc("rd_c1", 1, 0, 32'h100, 32'h0, 1, 1, 0);
    next_cycle(); start_rd = 1'b1; #1;
    chk_cyc("rd_c2", 1, 0, 32'h104, 32'h0, 1, 1, 0);
    next_cycle(); start_rd = 1'b0; #1;
    chk_cyc("rd_c3", 1, 0, 32'h108, 32'h0, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("rd_c4", 1, 0, 32'h10C, 32'h0, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("rd_c5_finish", 0, 0, 32'h0, 32'h0, 0, 1, 1);
    next_cycle(); #1;
    chk_cyc("rd_c6_idle", 0, 0, 32'h0, 32'h0, 0, 0, 0);
    check("rd_rdata", rdata_vec, exp_rd1);
    next_cycle(); #1;
    chk_cyc("rd_c7_no_requeue", 0, 0, 32'h0, 32'h0, 0, 0, 0);
    check("rd_done_count", 128'(done_cnt - d0), 128'd1);
    check("rd_access_count", 128'(acc_cnt - a0), 128'd4);

    // Write at base 0x200 with ready low in cycle 2 only
    next_cycle();
    wdata_vec = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    start_wr = 1'b1; base_addr = 32'h200; #1;
    chk_cyc("wr_c0", 0, 0, 32'h0, 32'h0, 1, 0, 0);
    next_cycle(); start_wr = 1'b0; wdata_vec = '0; #1;
    chk_cyc("wr_c1", 0, 1, 32'h200, 32'hAAAA0001, 1, 1, 0);
    next_cycle(); ready = 1'b0; #1;
    chk_cyc("wr_c2_wait", 0, 1, 32'h204, 32'hBBBB0002, 1, 1, 0);
    next_cycle(); ready = 1'b1; #1;
    chk_cyc("wr_c3_held", 0, 1, 32'h204, 32'hBBBB0002, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("wr_c4", 0, 1, 32'h208, 32'hCCCC0003, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("wr_c5", 0, 1, 32'h20C, 32'hDDDD0004, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("wr_c6_finish", 0, 0, 32'h0, 32'h0, 0, 1, 1);
    check("wr_rdata_unchanged", rdata_vec, exp_rd1);

    // Simultaneous start_rd and start_wr: the write must win
    next_cycle(); next_cycle();
    wdata_vec = {32'h44, 32'h33, 32'h22, 32'h11};
    start_wr = 1'b1; start_rd = 1'b1; base_addr = 32'h300; #1;
    chk_cyc("both_c0", 0, 0, 32'h0, 32'h0, 1, 0, 0);
    next_cycle(); start_wr = 1'b0; start_rd = 1'b0; wdata_vec = '0; #1;
    chk_cyc("both_c1", 0, 1, 32'h300, 32'h11, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("both_c2", 0, 1, 32'h304, 32'h22, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("both_c3", 0, 1, 32'h308, 32'h33, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("both_c4", 0, 1, 32'h30C, 32'h44, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("both_c5_finish", 0, 0, 32'h0, 32'h0, 0, 1, 1);
    check("both_rdata_unchanged", rdata_vec, exp_rd1);

    // Address wrap around 2^32
    next_cycle(); next_cycle();
    start_rd = 1'b1; base_addr = 32'hFFFF_FFF8; #1;
    next_cycle(); start_rd = 1'b0; #1;
    chk_cyc("wrap_c1", 1, 0, 32'hFFFF_FFF8, 32'h0, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("wrap_c2", 1, 0, 32'hFFFF_FFFC, 32'h0, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("wrap_c3", 1, 0, 32'h0000_0000, 32'h0, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("wrap_c4", 1, 0, 32'h0000_0004, 32'h0, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("wrap_c5_finish", 0, 0, 32'h0, 32'h0, 0, 1, 1);
    next_cycle(); #1;
    check("wrap_rdata", rdata_vec, exp_wrap);

    // Reset asserted during lane 2 of a read
    next_cycle();
    start_rd = 1'b1; base_addr = 32'h400; #1;
    next_cycle(); start_rd = 1'b0; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    chk_cyc("rst_lane2_active", 1, 0, 32'h408, 32'h0, 1, 1, 0);
    d0 = done_cnt;
    rst_n = 1'b0; #1;
    chk_cyc("rst_abort", 0, 0, 32'h0, 32'h0, 0, 0, 0);
    check("rst_rdata_cleared", rdata_vec, 128'h0);
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    next_cycle(); #1;
    chk_cyc("rst_idle_after", 0, 0, 32'h0, 32'h0, 0, 0, 0);
    check("rst_no_done", 128'(done_cnt - d0), 128'd0);

    // Fresh read after reset release
    start_rd = 1'b1; base_addr = 32'h500; #1;
    next_cycle(); start_rd = 1'b0; #1;
    chk_cyc("fresh_c1", 1, 0, 32'h500, 32'h0, 1, 1, 0);
    next_cycle(); next_cycle(); next_cycle(); #1;
    chk_cyc("fresh_c4", 1, 0, 32'h50C, 32'h0, 1, 1, 0);
    next_cycle(); #1;
    chk_cyc("fresh_c5_finish", 0, 0, 32'h0, 32'h0, 0, 1, 1);
    next_cycle(); #1;
    check("fresh_rdata", rdata_vec, exp_rd5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
